// File: rtl/frame_config_sequencer.sv
// Frame configuration sequencer: parses a 32-bit configuration word stream,
// assembles NumberOfRows-word frames into FrameData, then emits a one-cycle
// FrameStrobe with the target column and a one-hot frame address for the
// per-column frame select decoders.
module frame_config_sequencer #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int NumColumns       = 10,
  parameter int NumberOfRows     = 16,
  parameter int FrameBitsPerRow  = 32
) (
  input  logic                                  CLK,
  input  logic                                  resetn,
  input  logic [31:0]                           WriteData,
  input  logic                                  WriteStrobe,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]            FrameAddress,
  output logic [FrameSelectWidth-1:0]           FrameSelect,
  output logic                                  FrameStrobe,
  output logic                                  ConfigActive,
  output logic                                  FrameError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
  localparam int          ROW_BITS    = FrameBitsPerRow;
  localparam int          ROW_W       = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NumberOfRows - 1);
  // One extra bit so a column limit of 2**FrameSelectWidth is representable.
  localparam logic [FrameSelectWidth:0] NUM_COLS = (FrameSelectWidth + 1)'(NumColumns);
  localparam logic [7:0]  MAX_IDX     = 8'(MaxFramesPerCol);
  localparam logic [MaxFramesPerCol-1:0] ADDR_ONE = MaxFramesPerCol'(1);

  state_t                      state;
  logic [ROW_W-1:0]            row_cnt;
  logic [FrameSelectWidth-1:0] pend_col;
  logic [6:0]                  pend_idx;
  logic                        discard;

  // Header field decode of the current word.
  logic [FrameSelectWidth-1:0] hdr_col;
  logic [6:0]                  hdr_idx;
  logic                        is_header;
  logic                        hdr_bad;

  assign hdr_col   = WriteData[23 +: FrameSelectWidth];
  assign hdr_idx   = WriteData[22:16];
  assign is_header = (WriteData[31:28] == 4'hA);
  // The index is range-checked on the full 7-bit field so an out-of-range
  // index can never alias onto a legal one-hot position.
  assign hdr_bad   = ({1'b0, hdr_col} >= NUM_COLS) || ({1'b0, hdr_idx} >= MAX_IDX);

  // Parser FSM, frame assembly and registered strobe launch.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      row_cnt      <= '0;
      pend_col     <= '0;
      pend_idx     <= '0;
      discard      <= 1'b0;
      // NOTE: FrameData is a plain register bank driven straight to the
      // decoders, so it is reset with everything else; a RAM would not be.
      FrameData    <= '0;
      FrameAddress <= '0;
      FrameSelect  <= '0;
      FrameStrobe  <= 1'b0;
      ConfigActive <= 1'b0;
      FrameError   <= 1'b0;
    end else begin
      // NOTE: defaults at the top of a clocked block make these true one-cycle
      // pulses; any later non-blocking assignment in the same cycle wins.
      FrameStrobe  <= 1'b0;
      FrameAddress <= '0;

      if (WriteStrobe) begin
        case (state)
          IDLE: begin
            if (WriteData == SYNC_WORD) begin
              state        <= HEADER;
              ConfigActive <= 1'b1;
              FrameError   <= 1'b0;
            end
          end

          HEADER: begin
            if (WriteData == DESYNC_WORD) begin
              state        <= IDLE;
              ConfigActive <= 1'b0;
            end else if (WriteData == SYNC_WORD) begin
              FrameError <= 1'b0;
            end else if (is_header) begin
              // Only pending registers change here, so a header arriving
              // during a strobe cycle never disturbs FrameSelect/FrameAddress.
              pend_col <= hdr_col;
              pend_idx <= hdr_idx;
              row_cnt  <= '0;
              discard  <= hdr_bad;
              if (hdr_bad) FrameError <= 1'b1;
              state    <= DATA;
            end else begin
              FrameError <= 1'b1;
            end
          end

          DATA: begin
            // NOTE: non-blocking assignment everywhere in sequential logic so
            // every register samples pre-edge values regardless of order.
            FrameData[ROW_BITS*row_cnt +: ROW_BITS] <= WriteData;
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= HEADER;
              discard <= 1'b0;
              // A discarded frame is still fully consumed to keep the stream
              // aligned; it just never reaches the decoders.
              if (!discard) begin
                FrameStrobe  <= 1'b1;
                FrameSelect  <= pend_col;
                FrameAddress <= ADDR_ONE << pend_idx;
              end
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed self-checking bench for frame_config_sequencer.
module tb_frame_config_sequencer;

  localparam int MAX_FRAMES = 20;
  localparam int SEL_W      = 5;
  localparam int NUM_COLS   = 10;
  localparam int ROWS       = 16;
  localparam int ROW_BITS   = 32;

  logic                       CLK;
  logic                       resetn;
  logic [31:0]                WriteData;
  logic                       WriteStrobe;
  logic [ROWS*ROW_BITS-1:0]   FrameData;
  logic [MAX_FRAMES-1:0]      FrameAddress;
  logic [SEL_W-1:0]           FrameSelect;
  logic                       FrameStrobe;
  logic                       ConfigActive;
  logic                       FrameError;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int strobe_base = 0;

  frame_config_sequencer #(
    .MaxFramesPerCol (MAX_FRAMES),
    .FrameSelectWidth(SEL_W),
    .NumColumns      (NUM_COLS),
    .NumberOfRows    (ROWS),
    .FrameBitsPerRow (ROW_BITS)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .FrameData   (FrameData),
    .FrameAddress(FrameAddress),
    .FrameSelect (FrameSelect),
    .FrameStrobe (FrameStrobe),
    .ConfigActive(ConfigActive),
    .FrameError  (FrameError)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count strobe cycles; read at the edge so the pre-edge value is seen.
  always @(posedge CLK) if (FrameStrobe) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one strobed word; returns at the following falling edge.
  task automatic put(input logic [31:0] w);
    WriteData   = w;
    WriteStrobe = 1'b1;
    @(negedge CLK);
    WriteStrobe = 1'b0;
  endtask

  task automatic idle(input int n);
    WriteStrobe = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [31:0] row(input int r);
    return FrameData[r*ROW_BITS +: ROW_BITS];
  endfunction

  initial begin
    resetn      = 1'b0;
    WriteData   = '0;
    WriteStrobe = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_strobe", 32'(FrameStrobe), 32'd0);
    check("rst_addr",   32'(FrameAddress), 32'd0);
    check("rst_sel",    32'(FrameSelect), 32'd0);
    check("rst_active", 32'(ConfigActive), 32'd0);
    check("rst_error",  32'(FrameError), 32'd0);
    check("rst_row0",   row(0), 32'd0);
    check("rst_row15",  row(15), 32'd0);
    resetn = 1'b1;
    idle(2);

    // Before any sync: header and data are ignored
    strobe_base = strobe_cnt;
    put(32'hA183_0000);
    for (int r = 0; r < ROWS; r++) put(32'hBAD0_0000 + 32'(r));
    idle(2);
    check("presync_active", 32'(ConfigActive), 32'd0);
    check("presync_strobes", 32'(strobe_cnt - strobe_base), 32'd0);
    check("presync_row0", row(0), 32'd0);

    // Test 1: back-to-back frame col 3 idx 3
    put(32'hFAB0_FAB1);
    check("t1_active", 32'(ConfigActive), 32'd1);
    put(32'hA183_0000);
    strobe_base = strobe_cnt;
    for (int r = 0; r < ROWS; r++) begin
      put(32'(r));
      if (r == ROWS - 2) check("t1_no_early_strobe", 32'(FrameStrobe), 32'd0);
    end
    check("t1_strobe", 32'(FrameStrobe), 32'd1);
    check("t1_sel",    32'(FrameSelect), 32'd3);
    check("t1_addr",   32'(FrameAddress), 32'h0_0008);
    check("t1_error",  32'(FrameError), 32'd0);
    check("t1_active2", 32'(ConfigActive), 32'd1);
    for (int r = 0; r < ROWS; r++) check($sformatf("t1_row%0d", r), row(r), 32'(r));
    idle(1);
    check("t1_strobe_off", 32'(FrameStrobe), 32'd0);
    check("t1_addr_off",   32'(FrameAddress), 32'd0);
    check("t1_sel_hold",   32'(FrameSelect), 32'd3);
    check("t1_strobe_count", 32'(strobe_cnt - strobe_base), 32'd1);

    // Test 2: same frame with 3 idle cycles between data words
    put(32'hA183_0000);
    strobe_base = strobe_cnt;
    for (int r = 0; r < ROWS; r++) begin
      put(32'(r));
      if (r < ROWS - 1) idle(3);
      if (r == ROWS - 2) check("t2_no_early_strobe", 32'(FrameStrobe), 32'd0);
    end
    check("t2_strobe", 32'(FrameStrobe), 32'd1);
    check("t2_sel",    32'(FrameSelect), 32'd3);
    check("t2_addr",   32'(FrameAddress), 32'h0_0008);
    check("t2_row9",   row(9), 32'd9);
    idle(1);
    check("t2_strobe_off", 32'(FrameStrobe), 32'd0);
    check("t2_strobe_count", 32'(strobe_cnt - strobe_base), 32'd1);

    // Test 3: column 12 is discarded, then col 0 idx 19 launches
    put(32'hA600_0000);
    check("t3_error_set", 32'(FrameError), 32'd1);
    strobe_base = strobe_cnt;
    for (int r = 0; r < ROWS; r++) put(32'hDEAD_0000 + 32'(r));
    idle(2);
    check("t3_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);
    check("t3_row5_written", row(5), 32'hDEAD_0005);
    put(32'hA013_0000);
    strobe_base = strobe_cnt;
    for (int r = 0; r < ROWS; r++) put(32'h0000_5000 + 32'(r));
    check("t3_strobe", 32'(FrameStrobe), 32'd1);
    check("t3_sel",    32'(FrameSelect), 32'd0);
    check("t3_addr",   32'(FrameAddress), 32'h8_0000);
    check("t3_error_sticky", 32'(FrameError), 32'd1);
    check("t3_row15",  row(15), 32'h0000_500F);
    idle(1);
    check("t3_strobe_count", 32'(strobe_cnt - strobe_base), 32'd1);

    // Test 4: desync returns to IDLE; later header is ignored
    put(32'hFAB0_FAB0);
    check("t4_inactive", 32'(ConfigActive), 32'd0);
    strobe_base = strobe_cnt;
    put(32'hA183_0000);
    for (int r = 0; r < ROWS; r++) put(32'h7777_0000 + 32'(r));
    idle(2);
    check("t4_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);
    check("t4_row0_kept", row(0), 32'h0000_5000);
    check("t4_inactive2", 32'(ConfigActive), 32'd0);

    // Test 5: sync clears error; junk sets it; sync clears it again
    put(32'hFAB0_FAB1);
    check("t5_sync_clear", 32'(FrameError), 32'd0);
    put(32'h1234_5678);
    check("t5_junk_error", 32'(FrameError), 32'd1);
    put(32'hFAB0_FAB1);
    check("t5_resync_clear", 32'(FrameError), 32'd0);
    check("t5_active", 32'(ConfigActive), 32'd1);

    // Test 6: reset mid-frame, then a fresh frame with a desync pattern as data
    put(32'hA183_0000);
    strobe_base = strobe_cnt;
    for (int r = 0; r < 8; r++) put(32'h4444_0000 + 32'(r));
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_active", 32'(ConfigActive), 32'd0);
    check("t6_rst_row0",   row(0), 32'd0);
    check("t6_rst_strobe", 32'(FrameStrobe), 32'd0);
    @(negedge CLK);
    resetn = 1'b1;
    idle(3);
    check("t6_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);
    put(32'hFAB0_FAB1);
    put(32'hA092_0000);
    strobe_base = strobe_cnt;
    for (int r = 0; r < ROWS; r++) put((r == 3) ? 32'hFAB0_FAB0 : 32'hC0DE_0000 + 32'(r));
    check("t6_strobe", 32'(FrameStrobe), 32'd1);
    check("t6_sel",    32'(FrameSelect), 32'd1);
    check("t6_addr",   32'(FrameAddress), 32'h4_0000);
    check("t6_row3_desync_data", row(3), 32'hFAB0_FAB0);
    check("t6_row4",   row(4), 32'hC0DE_0004);
    check("t6_row8",   row(8), 32'hC0DE_0008);
    check("t6_active", 32'(ConfigActive), 32'd1);
    idle(1);
    check("t6_strobe_off", 32'(FrameStrobe), 32'd0);
    check("t6_strobe_count", 32'(strobe_cnt - strobe_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
